// File: rtl/tomasulo_pkg.sv
// rtl/tomasulo_pkg.sv - shared Tomasulo writeback parameters and result type
package tomasulo_pkg;
   localparam int no_ALU_units    = 3;
   localparam int no_MulDiv_units = 1;
   localparam int NUM_FU_SRC      = no_ALU_units + 2*no_MulDiv_units;
   localparam int CDB_WIDTH       = 3;
   localparam int FU_FIFO_DEPTH   = 4;
   localparam int FU_XLEN         = 32;
   localparam int FU_TAG_W        = 6;

   typedef struct packed {
      logic                valid;
      logic [FU_TAG_W-1:0] tag;
      logic [FU_XLEN-1:0]  data;
   } FU_Result_t;
endpackage

// File: rtl/fu_result_fifo.sv
// rtl/fu_result_fifo.sv - per-source result FIFO with async reset and sync flush
module fu_result_fifo #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32,
   parameter int TAG_W = 6
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [TAG_W-1:0]         push_tag_i,
   input  logic [XLEN-1:0]          push_data_i,
   output logic [TAG_W-1:0]         head_tag_o,
   output logic [XLEN-1:0]          head_data_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [TAG_W+XLEN-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]      wr_q, rd_q;
   logic [PTR_W:0]        cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (flush_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + 1'b1;
         if (pop_i)  rd_q <= rd_q + 1'b1;
         case ({push_i, pop_i})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Storage needs no reset: the head is only consumed when the FIFO is non-empty.
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_q] <= {push_tag_i, push_data_i};
   end

   assign {head_tag_o, head_data_o} = mem_q[rd_q];
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
endmodule

// File: rtl/fu_result_arbiter.sv
// rtl/fu_result_arbiter.sv - FU writeback: per-source FIFOs, round-robin CDB arbitration
module fu_result_arbiter
   import tomasulo_pkg::*;
#(
   parameter int NUM_SRC = NUM_FU_SRC,
   parameter int CDB_W   = CDB_WIDTH,
   parameter int DEPTH   = FU_FIFO_DEPTH,
   parameter int XLEN    = FU_XLEN,
   parameter int TAG_W   = FU_TAG_W,
   localparam int SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
   localparam int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       cdb_stall,
   input  logic [NUM_SRC-1:0]         src_valid,
   input  logic [NUM_SRC*TAG_W-1:0]   src_tag,
   input  logic [NUM_SRC*XLEN-1:0]    src_data,
   output logic [NUM_SRC-1:0]         src_ready,
   output logic [CDB_W-1:0]           cdb_valid,
   output logic [CDB_W*TAG_W-1:0]     cdb_tag,
   output logic [CDB_W*XLEN-1:0]      cdb_data,
   output logic [CDB_W*SRC_W-1:0]     cdb_src,
   output logic [NUM_SRC*CNT_W-1:0]   src_count
);
   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [XLEN-1:0]  data;
      logic [SRC_W-1:0] src;
   } lane_t;

   logic [NUM_SRC-1:0] empty, push, pop, grant;
   logic [TAG_W-1:0]   head_tag  [NUM_SRC];
   logic [XLEN-1:0]    head_data [NUM_SRC];
   logic [CNT_W-1:0]   count     [NUM_SRC];

   logic [SRC_W-1:0]   rr_q, rr_d;
   lane_t              lane_q [CDB_W];
   lane_t              lane_d [CDB_W];

   assign push = src_valid & src_ready & ~{NUM_SRC{flush}};
   assign pop  = grant & {NUM_SRC{!cdb_stall && !flush}};

   for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      fu_result_fifo #(.DEPTH(DEPTH), .XLEN(XLEN), .TAG_W(TAG_W)) u_fifo (
         .clk         (clk),
         .rst_n       (rst_n),
         .flush_i     (flush),
         .push_i      (push[s]),
         .pop_i       (pop[s]),
         .push_tag_i  (src_tag[s*TAG_W +: TAG_W]),
         .push_data_i (src_data[s*XLEN +: XLEN]),
         .head_tag_o  (head_tag[s]),
         .head_data_o (head_data[s]),
         .empty_o     (empty[s]),
         .count_o     (count[s])
      );
      assign src_ready[s] = (count[s] < CNT_W'(DEPTH));
      assign src_count[s*CNT_W +: CNT_W] = count[s];
   end

   // Scan order starts at rr_q; the j-th non-empty source found fills lane j.
   always_comb begin
      int n;
      n     = 0;
      grant = '0;
      rr_d  = rr_q;
      for (int k = 0; k < CDB_W; k++) lane_d[k] = '0;
      for (int j = 0; j < NUM_SRC; j++) begin
         for (int s = 0; s < NUM_SRC; s++) begin
            if (s == (int'(rr_q) + j) % NUM_SRC && !empty[s] && n < CDB_W) begin
               grant[s] = 1'b1;
               for (int k = 0; k < CDB_W; k++) begin
                  if (k == n) lane_d[k] = '{valid: 1'b1, tag: head_tag[s],
                                            data: head_data[s], src: SRC_W'(s)};
               end
               rr_d = SRC_W'((s + 1) % NUM_SRC);
               n    = n + 1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q <= '0;
         for (int k = 0; k < CDB_W; k++) lane_q[k] <= '0;
      end else if (flush) begin
         rr_q <= '0;
         for (int k = 0; k < CDB_W; k++) lane_q[k] <= '0;
      end else if (!cdb_stall) begin
         rr_q <= rr_d;
         for (int k = 0; k < CDB_W; k++) lane_q[k] <= lane_d[k];
      end
   end

   for (genvar k = 0; k < CDB_W; k++) begin : g_lane
      assign cdb_valid[k]                  = lane_q[k].valid;
      assign cdb_tag[k*TAG_W +: TAG_W]     = lane_q[k].tag;
      assign cdb_data[k*XLEN +: XLEN]      = lane_q[k].data;
      assign cdb_src[k*SRC_W +: SRC_W]     = lane_q[k].src;
   end
endmodule
